// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit (i2sout) and receive (i2sin) ends of the link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_pkg;

    // Receiver framing state
    typedef enum logic [1:0] {
        UNSYNC     = 2'd0,
        RIGHT_SKIP = 2'd1,
        LEFT       = 2'd2,
        RIGHT      = 2'd3
    } i2s_state_e;

    // Word-select encoding
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // The sample carrying a ws transition holds no data bit
    localparam int DELAY_SLOTS = 1;

    // Bit-counter width able to hold 0..bits inclusive
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/i2s_deser.sv
// Serial-to-parallel shift register with a saturating bit counter.
// Latency: a shifted bit is visible on word_o one clock after the shift edge.
// Backpressure: none; shifts are ignored once full_o is set, clear_i wins over shift_i.
//
// Ports:
//   clk_i, rst_i         - bit clock, asynchronous active-high reset
//   clear_i              - restart the count (shift register contents kept)
//   shift_i, sd_i        - shift sd_i into the LSB when not full
//   word_o               - current shift register contents
//   word_next_o          - contents as they will be after shifting sd_i in
//   full_o               - count has reached BITS
//   last_o               - count is BITS-1 (the next shift completes the word)
module i2s_deser
    import i2s_pkg::*;
#(
    parameter int BITS = 24
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            shift_i,
    input  logic            sd_i,
    output logic [BITS-1:0] word_o,
    output logic [BITS-1:0] word_next_o,
    output logic            full_o,
    output logic            last_o
);

    localparam int CW = cnt_width(BITS);

    logic [BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign word_o      = sr_q;
    assign word_next_o = {sr_q[BITS-2:0], sd_i};
    assign full_o      = (cnt_q == CW'(BITS));
    assign last_o      = (cnt_q == CW'(BITS - 1));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i && !full_o) begin
            sr_d  = word_next_o;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2sin.sv
// I2S receiver: deserialises MSB-first stereo words and presents each L/R pair in parallel.
// Latency: data_valid rises the sck cycle after the right-channel LSB is sampled.
// Backpressure: none; the sink must accept every data_valid strobe, outputs hold between strobes.
//
// Ports:
//   sck, rst             - bit clock (rising edge), asynchronous active-high reset
//   ws, sd               - word select (0 left / 1 right) and serial data
//   l_data, r_data       - last complete left/right word pair
//   data_valid           - one-cycle strobe for a new pair
//   synced               - sticky frame-lock indicator
//   frame_err            - one-cycle strobe when a channel ended short
module i2sin
    import i2s_pkg::*;
#(
    parameter int BITS_PRECISION = 24
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic                      ws,
    input  logic                      sd,
    output logic [BITS_PRECISION-1:0] l_data,
    output logic [BITS_PRECISION-1:0] r_data,
    output logic                      data_valid,
    output logic                      synced,
    output logic                      frame_err
);

    localparam int BP = BITS_PRECISION;

    i2s_state_e state_q, state_d;

    logic          ws_q;
    logic [BP-1:0] l_hold_q, l_hold_d;
    logic          l_ok_q, l_ok_d;
    logic [BP-1:0] l_data_q, l_data_d;
    logic [BP-1:0] r_data_q, r_data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          synced_q, synced_d;

    logic          ws_rise, ws_fall, ws_edge;
    logic [BP-1:0] word, word_next;
    logic          full, last;
    logic          word_done;

    assign ws_rise = (ws == WS_RIGHT) && (ws_q == WS_LEFT);
    assign ws_fall = (ws == WS_LEFT)  && (ws_q == WS_RIGHT);
    assign ws_edge = ws_rise || ws_fall;

    // The edge sample is the delay slot: it restarts the count and its sd is
    // dropped. Because the edge takes priority, an edge landing on what would
    // have been the final data bit leaves the word one bit short.
    assign word_done = !ws_edge && last;

    i2s_deser #(
        .BITS(BP)
    ) u_deser (
        .clk_i      (sck),
        .rst_i      (rst),
        .clear_i    (ws_edge),
        .shift_i    (!ws_edge),
        .sd_i       (sd),
        .word_o     (word),
        .word_next_o(word_next),
        .full_o     (full),
        .last_o     (last)
    );

    // State register
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q <= UNSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNSYNC:     if (ws_rise) state_d = RIGHT_SKIP;
            RIGHT_SKIP: if (ws_fall) state_d = LEFT;
            LEFT:       if (ws_rise) state_d = RIGHT;
            RIGHT:      if (ws_fall) state_d = LEFT;
            default:    state_d = UNSYNC;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        l_hold_d = l_hold_q;
        l_ok_d   = l_ok_q;
        l_data_d = l_data_q;
        r_data_d = r_data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        synced_d = synced_q;
        case (state_q)
            RIGHT_SKIP: begin
                // The right word in flight at lock time has no matching left word
                if (ws_fall) synced_d = 1'b1;
            end
            LEFT: begin
                if (ws_rise) begin
                    if (full) begin
                        l_hold_d = word;
                        l_ok_d   = 1'b1;
                    end else begin
                        l_ok_d   = 1'b0;
                        err_d    = 1'b1;
                    end
                end
            end
            RIGHT: begin
                // Pair is released as soon as the right LSB lands, not at the next edge
                if (word_done && l_ok_q) begin
                    l_data_d = l_hold_q;
                    r_data_d = word_next;
                    valid_d  = 1'b1;
                end
                if (ws_fall && !full) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            ws_q     <= WS_LEFT;
            l_hold_q <= '0;
            l_ok_q   <= 1'b0;
            l_data_q <= '0;
            r_data_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            ws_q     <= ws;
            l_hold_q <= l_hold_d;
            l_ok_q   <= l_ok_d;
            l_data_q <= l_data_d;
            r_data_q <= r_data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            synced_q <= synced_d;
        end
    end

    assign l_data     = l_data_q;
    assign r_data     = r_data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign synced     = synced_q;

endmodule

// File: tb/tb_i2sin.sv
// Self-checking bench for i2sin: table of frames plus hand-written corner sequences.
// Latency: checks data_valid lands one cycle after the right LSB sample.
// Backpressure: n/a (bench always accepts).
module tb_i2sin;
    import i2s_pkg::*;

    localparam int BP = 24;

    logic          sck = 1'b0;
    logic          rst = 1'b0;
    logic          ws  = 1'b0;
    logic          sd  = 1'b0;
    logic [BP-1:0] l_data, r_data;
    logic          data_valid, synced, frame_err;

    i2sin #(.BITS_PRECISION(BP)) dut (
        .sck       (sck),
        .rst       (rst),
        .ws        (ws),
        .sd        (sd),
        .l_data    (l_data),
        .r_data    (r_data),
        .data_valid(data_valid),
        .synced    (synced),
        .frame_err (frame_err)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [BP-1:0] l;
        logic [BP-1:0] r;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [BP-1:0] l;
        logic [BP-1:0] r;
        int            lb;
        int            rb;
        int            pad;
        int            exp_vld;
        int            exp_err;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[14];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            vld_cnt = 0;
    int            err_cnt = 0;
    logic [BP-1:0] last_l = '0;
    logic [BP-1:0] last_r = '0;

    always @(posedge sck) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: sample #1 after the active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge sck);
            #1;
            if (frame_err === 1'b1) err_cnt++;
            if (data_valid === 1'b1) begin
                vld_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got l=0x%0h r=0x%0h with empty queue", l_data, r_data);
                end else begin
                    e = sb.pop_front();
                    chk("pair_l", 32'(l_data), 32'(e.l));
                    chk("pair_r", 32'(r_data), 32'(e.r));
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    last_l = e.l;
                    last_r = e.r;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    task automatic send_bit(input logic w, input logic d);
        @(negedge sck);
        ws = w;
        sd = d;
    endtask

    // One channel: delay slot, nbits data MSB first, then pad filler samples.
    // With push set, the pair is queued as the right LSB is driven.
    task automatic send_chan(input logic w, input logic [BP-1:0] word, input int nbits,
                             input int pad, input bit push, input logic [BP-1:0] lword);
        exp_t e;
        for (int s = 0; s < DELAY_SLOTS; s++) send_bit(w, 1'($urandom));
        for (int i = 0; i < nbits; i++) begin
            send_bit(w, word[BP-1-i]);
            if (push && i == BP - 1) begin
                e.l = lword;
                e.r = word;
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
        end
        for (int i = 0; i < pad; i++) send_bit(w, 1'($urandom));
    endtask

    task automatic send_frame(input logic [BP-1:0] l, input logic [BP-1:0] r, input int lb,
                              input int rb, input int pad, input bit push);
        send_chan(WS_LEFT, l, lb, pad, 1'b0, '0);
        send_chan(WS_RIGHT, r, rb, pad, push, l);
    endtask

    initial begin
        int v0, e0;

        // Frame table: 8 nominal frames, then short/edge-wins/padded cases
        for (int n = 0; n < 8; n++) begin
            vecs[n] = '{l: BP'(n), r: ~(BP'(n)), lb: BP, rb: BP, pad: 0, exp_vld: 1, exp_err: 0};
        end
        vecs[8]  = '{l: 24'h111111, r: 24'h222222, lb: 20, rb: BP, pad: 0, exp_vld: 0, exp_err: 1};
        vecs[9]  = '{l: 24'h333333, r: 24'h444444, lb: BP, rb: BP, pad: 0, exp_vld: 1, exp_err: 0};
        vecs[10] = '{l: 24'h555555, r: 24'h666666, lb: 23, rb: BP, pad: 0, exp_vld: 0, exp_err: 1};
        vecs[11] = '{l: 24'h777777, r: 24'h888888, lb: BP, rb: BP, pad: 0, exp_vld: 1, exp_err: 0};
        vecs[12] = '{l: 24'hC0FFEE, r: 24'hBADF00, lb: BP, rb: BP, pad: 7, exp_vld: 1, exp_err: 0};
        vecs[13] = '{l: 24'h0F0F0F, r: 24'hF0F0F0, lb: BP, rb: BP, pad: 7, exp_vld: 1, exp_err: 0};

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge sck);
        chk("rst_l_data", 32'(l_data), 32'h0);
        chk("rst_r_data", 32'(r_data), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_synced", 32'(synced), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;

        // Loopback start from idle: first pair is lost, second pair delivered
        send_frame(24'hA5A5A5, 24'h5A5A5A, BP, BP, 0, 1'b0);
        @(posedge sck); #2;
        chk("synced_before_fall", 32'(synced), 32'h0);
        chk("lost_pair_no_valid", 32'(vld_cnt), 32'h0);
        send_chan(WS_LEFT, 24'h123456, BP, 0, 1'b0, '0);
        chk("synced_after_fall", 32'(synced), 32'h1);
        send_chan(WS_RIGHT, 24'hFEDCBA, BP, 0, 1'b1, 24'h123456);
        @(posedge sck); #2;
        chk("first_pair_count", 32'(vld_cnt), 32'h1);
        chk("first_pair_no_err", 32'(err_cnt), 32'h0);

        // Table-driven frames
        for (int k = 0; k < 14; k++) begin
            v0 = vld_cnt;
            e0 = err_cnt;
            send_frame(vecs[k].l, vecs[k].r, vecs[k].lb, vecs[k].rb, vecs[k].pad, vecs[k].exp_vld != 0);
            @(posedge sck); #2;
            chk($sformatf("vec%0d_valid", k), 32'(vld_cnt - v0), 32'(vecs[k].exp_vld));
            chk($sformatf("vec%0d_err", k), 32'(err_cnt - e0), 32'(vecs[k].exp_err));
            chk($sformatf("vec%0d_hold_l", k), 32'(l_data), 32'(last_l));
            chk($sformatf("vec%0d_hold_r", k), 32'(r_data), 32'(last_r));
        end

        // Short right channel: error reported at the following ws fall, next frame recovers
        v0 = vld_cnt;
        e0 = err_cnt;
        send_chan(WS_LEFT, 24'hABCDEF, BP, 0, 1'b0, '0);
        send_chan(WS_RIGHT, 24'h13579B, 20, 0, 1'b0, '0);
        send_frame(24'h2468AC, 24'h369CF0, BP, BP, 0, 1'b1);
        @(posedge sck); #2;
        chk("rshort_err", 32'(err_cnt - e0), 32'h1);
        chk("rshort_valid", 32'(vld_cnt - v0), 32'h1);

        // Reset mid right word, then relock and resume
        send_chan(WS_LEFT, 24'h999999, BP, 0, 1'b0, '0);
        for (int i = 0; i < 11; i++) send_bit(WS_RIGHT, 1'($urandom));
        #1 rst = 1'b1;
        #1;
        chk("midrst_l_data", 32'(l_data), 32'h0);
        chk("midrst_r_data", 32'(r_data), 32'h0);
        chk("midrst_synced", 32'(synced), 32'h0);
        @(negedge sck);
        rst = 1'b0;
        last_l = '0;
        last_r = '0;
        v0 = vld_cnt;
        for (int i = 0; i < 5; i++) send_bit(WS_RIGHT, 1'($urandom));
        send_frame(24'hDEAD01, 24'hBEEF02, BP, BP, 0, 1'b1);
        send_frame(24'h00C0DE, 24'hFACE00, BP, BP, 0, 1'b1);
        @(posedge sck); #2;
        chk("relock_synced", 32'(synced), 32'h1);
        chk("relock_valid", 32'(vld_cnt - v0), 32'h2);

        // Idle: ws held at left with toggling data
        v0 = vld_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 200; i++) send_bit(WS_LEFT, 1'(i & 1));
        @(posedge sck); #2;
        chk("idle_valid", 32'(vld_cnt - v0), 32'h0);
        chk("idle_err", 32'(err_cnt - e0), 32'h0);
        chk("idle_hold_l", 32'(l_data), 32'h00C0DE);
        chk("idle_hold_r", 32'(r_data), 32'hFACE00);
        chk("idle_synced", 32'(synced), 32'h1);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
